bytes_to_word16_writer: RTL

- Downstream sink for the byte-serial memory port of the bridge loader.
- Accepts byte writes and coalesces adjacent byte pairs into 16-bit words with byte enables.
- Buffers the words in a small FIFO and drains them to a 16-bit external RAM controller (PSRAM/SDRAM front end) over a valid/ready handshake.
- Write-only: loader data slots only write. Upstream read strobes are not connected.

---
 rtl/word16_pkg.sv | 21 ++
 rtl/sync_fifo.sv | 54 +++++
 rtl/bytes_to_word16_writer.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/word16_pkg.sv
// rtl/word16_pkg.sv - shared types and helpers for the byte-to-word16 write path
// Purpose: default word entry layout, full byte-enable constant and the
//          byte-lane helper used to place a byte inside a 16-bit word.
// Ports:   none (package).
package word16_pkg;

   localparam int         ADDR_W_DEFAULT = 23;
   localparam logic [1:0] BE_FULL        = 2'b11;

   typedef struct packed {
      logic [ADDR_W_DEFAULT-1:0] addr;
      logic [15:0]               data;
      logic [1:0]                be;
   } word_t;

   // Lane 1 is data[15:8] / be[1]; lane 0 is data[7:0] / be[0].
   function automatic logic lane_of(input logic addr_bit0, input logic big_endian);
      return big_endian ? ~addr_bit0 : addr_bit0;
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - show-ahead synchronous FIFO with count-based flags
// Purpose: generic word buffer; the head entry is visible on head_o whenever
//          empty_o is low. A push while full is accepted only if a pop
//          happens on the same edge.
// Ports:   clk, reset (sync, active-high); push_i/push_data_i write side;
//          pop_i read side; head_o, empty_o, full_o status.
module sync_fifo #(
   parameter type T     = logic [7:0],
   parameter int  DEPTH = 8
) (
   input  logic clk,
   input  logic reset,
   input  logic push_i,
   input  T     push_data_i,
   input  logic pop_i,
   output T     head_o,
   output logic empty_o,
   output logic full_o
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);

   T                 mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q;
   logic [PTR_W-1:0] rd_ptr_q;
   logic [CNT_W-1:0] count_q;
   logic             do_push;
   logic             do_pop;

   assign empty_o = (count_q == '0);
   assign full_o  = (count_q == CNT_W'(DEPTH));
   assign do_pop  = pop_i && !empty_o;
   assign do_push = push_i && (!full_o || do_pop);
   assign head_o  = mem_q[rd_ptr_q];

   // DEPTH is a power of two, so the pointers wrap naturally.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= push_data_i;
   end

endmodule

// File: rtl/bytes_to_word16_writer.sv
// rtl/bytes_to_word16_writer.sv - coalesce byte writes into 16-bit words for a RAM controller
// Purpose: pairs adjacent byte writes into words with byte enables, buffers
//          them and drains them over a valid/ready handshake.
// Ports:   clk, reset (sync, active-high);
//          byte_address/byte_wr_data/byte_wr byte write input, flush;
//          mem_addr/mem_data/mem_be/mem_req with mem_ack word output;
//          busy (work outstanding), overflow (sticky word drop).
module bytes_to_word16_writer
   import word16_pkg::*;
#(
   parameter int ADDR_W       = ADDR_W_DEFAULT,
   parameter int FIFO_DEPTH   = 8,
   parameter int IDLE_TIMEOUT = 15,
   parameter bit BIG_ENDIAN   = 1'b1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [31:0]       byte_address,
   input  logic [7:0]        byte_wr_data,
   input  logic              byte_wr,
   input  logic              flush,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [15:0]       mem_data,
   output logic [1:0]        mem_be,
   output logic              mem_req,
   input  logic              mem_ack,
   output logic              busy,
   output logic              overflow
);

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [15:0]       data;
      logic [1:0]        be;
   } entry_t;

   localparam int CNT_W = (IDLE_TIMEOUT < 2) ? 1 : $clog2(IDLE_TIMEOUT + 1);

   logic              pend_valid_q, pend_valid_d;
   entry_t            pend_q, pend_d;
   logic [CNT_W-1:0]  idle_cnt_q, idle_cnt_d;
   logic              overflow_q, overflow_d;

   logic              push;
   entry_t            push_word;
   logic              pop;
   logic              fifo_empty;
   logic              fifo_full;
   entry_t            head;

   logic [ADDR_W-1:0] wr_addr;
   logic              wr_lane;
   entry_t            wr_entry;
   logic              timeout_hit;

   assign wr_addr  = byte_address[ADDR_W:1];
   assign wr_lane  = lane_of(byte_address[0], BIG_ENDIAN);
   // The unused lane is kept at zero so a later merge can simply OR.
   assign wr_entry = '{addr: wr_addr,
                       data: wr_lane ? {byte_wr_data, 8'h00} : {8'h00, byte_wr_data},
                       be:   wr_lane ? 2'b10 : 2'b01};

   // Fires on the edge that completes IDLE_TIMEOUT idle cycles since the last write.
   assign timeout_hit = (IDLE_TIMEOUT != 0) && pend_valid_q &&
                        (idle_cnt_q == CNT_W'(IDLE_TIMEOUT - 1));

   assign pop = !fifo_empty && mem_ack;

   always_comb begin
      pend_valid_d = pend_valid_q;
      pend_d       = pend_q;
      push         = 1'b0;
      push_word    = pend_q;
      if (byte_wr) begin
         if (!pend_valid_q) begin
            pend_valid_d = 1'b1;
            pend_d       = wr_entry;
         end else if ((pend_q.addr == wr_addr) && !pend_q.be[wr_lane]) begin
            pend_d.data = pend_q.data | wr_entry.data;
            pend_d.be   = pend_q.be | wr_entry.be;
            if (pend_d.be == BE_FULL) begin
               push         = 1'b1;
               push_word    = pend_d;
               pend_valid_d = 1'b0;
            end
         end else begin
            // Address break or lane collision: retire the old word, start a new one.
            push   = 1'b1;
            pend_d = wr_entry;
         end
      end else if (pend_valid_q && (flush || timeout_hit)) begin
         push         = 1'b1;
         pend_valid_d = 1'b0;
      end
      idle_cnt_d = (byte_wr || !pend_valid_d) ? '0 : idle_cnt_q + CNT_W'(1);
      overflow_d = overflow_q | (push && fifo_full && !pop);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pend_valid_q <= 1'b0;
         pend_q       <= '0;
         idle_cnt_q   <= '0;
         overflow_q   <= 1'b0;
      end else begin
         pend_valid_q <= pend_valid_d;
         pend_q       <= pend_d;
         idle_cnt_q   <= idle_cnt_d;
         overflow_q   <= overflow_d;
      end
   end

   sync_fifo #(
      .T     (entry_t),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk         (clk),
      .reset       (reset),
      .push_i      (push),
      .push_data_i (push_word),
      .pop_i       (pop),
      .head_o      (head),
      .empty_o     (fifo_empty),
      .full_o      (fifo_full)
   );

   // Outputs read zero while nothing is queued, so stale storage never shows.
   assign mem_req  = !fifo_empty;
   assign mem_addr = fifo_empty ? '0 : head.addr;
   assign mem_data = fifo_empty ? '0 : head.data;
   assign mem_be   = fifo_empty ? '0 : head.be;
   assign busy     = pend_valid_q || !fifo_empty;
   assign overflow = overflow_q;

   generate
      if (ADDR_W < 31) begin : g_high_bits
         logic unused_high_addr;
         assign unused_high_addr = ^byte_address[31:ADDR_W+1];
      end
   endgenerate

endmodule
